// File: rtl/sync_full_adder_pkg.sv
// Shared types and helpers for the synchronised full adder.
// Holds the per-bit adder cell and the synchroniser depth limits.
package sync_full_adder_pkg;

   localparam int SYNC_MIN = 1;
   localparam int SYNC_MAX = 3;

   typedef struct packed {
      logic c;
      logic s;
   } fa_bit_t;

   // One ripple cell: sum and carry of three 1-bit addends.
   function automatic fa_bit_t full_add(input logic a, input logic b, input logic c);
      fa_bit_t r;
      r.s = a ^ b ^ c;
      r.c = (a & b) | (a & c) | (b & c);
      return r;
   endfunction

   // Out-of-range depths are pulled back into the supported window.
   function automatic int clamp_stages(input int n);
      if (n < SYNC_MIN) return SYNC_MIN;
      if (n > SYNC_MAX) return SYNC_MAX;
      return n;
   endfunction

endpackage

// File: rtl/sync_full_adder_sync_stage.sv
// 1-bit synchroniser: STAGES cascaded flops, async active-low clear.
module sync_stage #(
   parameter int STAGES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_full_adder.sv
// Input-synchronised, output-registered full adder (ripple form for WIDTH>1).
// Raw operands only reach the adder through the per-bit synchroniser chains.
module sync_full_adder
   import sync_full_adder_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_c,
   output logic [WIDTH-1:0] s_out,
   output logic             c_out
);

   localparam int STAGES = clamp_stages(SYNC_STAGES);

   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic             c_s;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   fa_bit_t [WIDTH-1:0] fa;

   sync_stage #(.STAGES(STAGES)) u_sync_c (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_c),
      .q     (c_s)
   );

   assign carry[0] = c_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sync_stage #(.STAGES(STAGES)) u_sync_a (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (in_a[i]),
         .q     (a_s[i])
      );
      sync_stage #(.STAGES(STAGES)) u_sync_b (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (in_b[i]),
         .q     (b_s[i])
      );
      assign fa[i]       = full_add(a_s[i], b_s[i], carry[i]);
      assign sum[i]      = fa[i].s;
      assign carry[i+1]  = fa[i].c;
   end

   // Carry-out is simply the MSB of the WIDTH+1 result; no overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_out <= '0;
         c_out <= 1'b0;
      end else begin
         s_out <= sum;
         c_out <= carry[WIDTH];
      end
   end

endmodule

// File: tb/tb_sync_full_adder.sv
// Bench for sync_full_adder: 1-bit/1-stage and 3-bit/2-stage instances
// checked against a delay-line model of a+b+c.
`timescale 1ns/100ps
module tb_sync_full_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic       s1, co1;
   logic [2:0] a3 = '0, b3 = '0, s3;
   logic       c3 = 1'b0, co3;

   int checks = 0;
   int errors = 0;

   // Delay lines of expected sums; index SYNC_STAGES is what the outputs show.
   int unsigned q1[$] = '{0, 0};
   int unsigned q3[$] = '{0, 0, 0};

   always #1 clk = ~clk;

   sync_full_adder #(.WIDTH(1), .SYNC_STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_a(a1), .in_b(b1), .in_c(c1),
      .s_out(s1), .c_out(co1)
   );

   sync_full_adder #(.WIDTH(3), .SYNC_STAGES(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_a(a3), .in_b(b3), .in_c(c3),
      .s_out(s3), .c_out(co3)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1 = '{0, 0};
         q3 = '{0, 0, 0};
      end else begin
         q1.push_front(int'(a1) + int'(b1) + int'(c1));
         void'(q1.pop_back());
         q3.push_front(int'(a3) + int'(b3) + int'(c3));
         void'(q3.pop_back());
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag);
      @(negedge clk);
      chk({tag, "_w1"}, {31'd0, co1, s1}, q1[1]);
      chk({tag, "_w3"}, {28'd0, co3, s3}, q3[2]);
   endtask

   logic [2:0] tt_in [5]  = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b111};
   logic [1:0] tt_exp [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};  // {c,s}
   logic [2:0] bb_in [4]  = '{3'b000, 3'b111, 3'b011, 3'b101};
   logic [1:0] bb_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b10};

   initial begin
      // Reset held with all-ones inputs; clear must show before any edge.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; a3 = 3'd7; b3 = 3'd7; c3 = 1'b1;
      #0.3;
      chk("rst_noedge", {co1, s1, co3, s3}, 6'd0);
      repeat (5) begin
         @(negedge clk);
         chk("rst_hold", {co1, s1, co3, s3}, 6'd0);
      end
      rst_n = 1'b1;

      // Truth table, each pattern held 100 ns.
      for (int p = 0; p < 5; p++) begin
         {a1, b1, c1} = tt_in[p];
         repeat (50) cyc("tt");
         chk($sformatf("tt_%0d", p), {30'd0, co1, s1}, {30'd0, tt_exp[p]});
      end

      // Latency: a steps just after an edge, visible on the 2nd edge.
      {a1, b1, c1} = 3'b000;
      repeat (4) cyc("lat_pre");
      @(posedge clk); #0.2;
      a1 = 1'b1;
      @(posedge clk); #0.2;
      chk("lat_edge1", {31'd0, s1}, 32'd0);
      @(posedge clk); #0.2;
      chk("lat_edge2", {31'd0, s1}, 32'd1);

      // Mid-run asynchronous reset pulse between edges.
      {a1, b1, c1} = 3'b111;
      repeat (4) cyc("mid_pre");
      chk("mid_settled", {30'd0, co1, s1}, 32'd3);
      @(posedge clk); #0.5;
      rst_n = 1'b0;
      #0.1;
      chk("mid_async", {30'd0, co1, s1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #0.2;
      chk("mid_rel1", {30'd0, co1, s1}, 32'd0);
      @(posedge clk); #0.2;
      chk("mid_rel2", {30'd0, co1, s1}, 32'd3);

      // Back-to-back pattern changes every cycle.
      for (int i = 0; i < 6; i++) begin
         cyc("b2b");
         if (i >= 2)
            chk($sformatf("b2b_%0d", i-2), {30'd0, co1, s1}, {30'd0, bb_exp[i-2]});
         if (i < 4) {a1, b1, c1} = bb_in[i];
      end

      // 3-bit, 2-stage instance: results three edges after application.
      @(negedge clk);
      a3 = 3'd7; b3 = 3'd7; c3 = 1'b1;
      repeat (2) @(posedge clk);
      #0.2;
      chk("w3_777_early", {28'd0, co3, s3}, {28'd0, q3[2][3:0]});
      @(posedge clk); #0.2;
      chk("w3_771", {28'd0, co3, s3}, 32'hf);
      @(negedge clk);
      a3 = 3'd3; b3 = 3'd4; c3 = 1'b0;
      repeat (3) @(posedge clk);
      #0.2;
      chk("w3_340", {28'd0, co3, s3}, 32'h7);

      // Randomised run on both instances.
      repeat (300) begin
         cyc("rnd");
         a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
         a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'($urandom);
      end
      repeat (3) cyc("rnd_tail");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_full_adder.md
Name: sync_full_adder

Overview:
- Input-synchronised, output-registered full adder. Used as the add primitive of the three-bit ALU datapath.
- Each operand bit passes through a per-bit D-flip-flop synchroniser chain.
- The synchronised bits feed a full-adder core that registers sum and carry-out on the same clock.
- The default configuration is a single-bit full adder. A width parameter allows a ripple-carry vector form.

Parameters:
- WIDTH, 1, operand width in bits. in_a, in_b and s_out are WIDTH bits; carry-in and carry-out are 1 bit.
- SYNC_STAGES, 1, number of flip-flops per input bit in the synchroniser chain. Legal range is 1..3.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_n  input  1  reset, asynchronous, active-low. Clears every flop in the block.
- in_a  input  WIDTH  operand A, asynchronous to clk.
- in_b  input  WIDTH  operand B, asynchronous to clk.
- in_c  input  1  carry-in, asynchronous to clk.
- s_out  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out.

Behaviour:
- One clock domain. rst_n is asynchronous, active-low.
- Reset:
  - While rst_n=0, all synchroniser flops, s_out and c_out are 0, regardless of clk.
  - Release is sampled on the next rising edge.
- Synchroniser:
  - Each bit of in_a, in_b and in_c goes through SYNC_STAGES cascaded DFFs.
  - The output of the last stage is the synchronised bit.
  - No combinational path from the raw inputs to the core.
- Core:
  - On each rising edge with rst_n=1: {c_out, s_out} <= a_s + b_s + c_s.
  - The add is unsigned, WIDTH+1 bits wide, with no truncation.
  - For WIDTH=1: s_out = a^b^c; c_out = ab | ac | bc.
  - For WIDTH>1: a ripple chain, bit i carry-in = bit i-1 carry-out, computed combinationally between the sync stage and the output register.
- Latency:
  - An input change that is stable before edge k appears at the outputs after edge k+SYNC_STAGES.
  - Default SYNC_STAGES=1 gives 2 edges.
  - Throughput is one result per cycle. No handshake; continuous operation.
- Mid-operation reset: outputs go to 0 immediately and pipeline contents are discarded. After release, valid results reappear SYNC_STAGES+1 edges after stable inputs.
- Held inputs keep the outputs constant; no glitches on the registered outputs.
- The all-ones case produces no overflow flag. c_out carries the MSB; for WIDTH=1 with 1+1+1 the result is s_out=1, c_out=1.

Decomposition:
- No shared package is required. SYNC_STAGES and WIDTH are local parameters of the top.
- One natural sub-module: sync_stage, a 1-bit SYNC_STAGES-deep DFF chain with clk, rst_n, d and q. Instantiate it once per input bit.
- The adder core is coded inline in the top.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with inputs a=1, b=1, c=1 -> s_out=0, c_out=0 throughout. The asynchronous clear takes effect with no clock edge needed.
- Truth table, WIDTH=1, 2 ns clock:
  - Apply (a,b,c) = 000, 100, 010, 110, 111, each held for 100 ns.
  - Required (s,c) after settling = (0,0), (1,0), (1,0), (0,1), (1,1).
- Latency: step a from 0 to 1 with b=c=0 just after an edge -> s_out rises exactly on the 2nd following rising edge, not before.
- Mid-run reset: with a=b=c=1 settled (s=1, c=1), pulse rst_n low asynchronously between edges -> outputs drop to 0 at once. After release they return to (1,1) two edges later.
- Back-to-back changes: toggle the input pattern every cycle through 000, 111, 011, 101 -> outputs follow the same sequence, each shifted by 2 cycles: (0,0), (1,1), (0,1), (0,1).
- Parameter sweep: WIDTH=3, SYNC_STAGES=2 with a=7, b=7, c=1 -> s_out=7, c_out=1 three edges after application. With a=3, b=4, c=0 -> s_out=7, c_out=0.
